product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the combinational signed Booth array multiplier.
- Consumes its (2N-1)-bit two's-complement products one per handshake and sums a programmed number of terms into a wide accumulator.
- Presents the final dot-product-style sum on a valid/ready output with a sticky overflow flag.
- Turns the single-shot multiplier into a usable multiply-accumulate datapath.

Parameters:
- N, 8: multiplier operand width; product input width is 2N-1.
- ACC_W, 24: accumulator and result width; must be >= 2N-1 (elaboration error otherwise).
- CNT_W, 8: width of the term-count field; max run length 2^CNT_W-1.

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- i_start  input  1  start-of-run pulse; sampled only in IDLE
- i_len  input  CNT_W  number of products to sum; latched on accepted i_start
- i_p  input  2N-1  signed product from multiplier (two's complement)
- i_valid  input  1  i_p valid
- o_ready  output  1  block accepts i_p this cycle
- o_sum  output  ACC_W  signed accumulated result
- o_valid  output  1  o_sum valid
- i_ready  input  1  downstream accepts o_sum
- o_busy  output  1  high in any state other than IDLE
- o_ovf  output  1  sticky signed-overflow flag for the current run

Behaviour:
- Reset (synchronous, active-high) has priority over everything. FSM goes to IDLE. o_sum=0, o_valid=0, o_ready=0, o_busy=0, o_ovf=0, remaining count=0. Reset mid-run discards the partial sum.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only; no combinational path from i_* to o_*.
- IDLE:
  - o_ready=0; i_valid is ignored.
  - i_start=1 and i_len!=0: latch remaining=i_len, clear accumulator and o_ovf, go to ACCUM.
  - i_start=1 and i_len==0: clear accumulator and o_ovf, go directly to DONE (sum 0).
- ACCUM:
  - o_ready=1.
  - Transfer occurs when i_valid && o_ready. On a transfer: acc <= acc + sext(i_p to ACC_W); remaining <= remaining-1.
  - The transfer with remaining==1 moves to DONE. The updated acc is visible on o_sum with o_valid=1 in the following cycle (1-cycle latency from last transfer).
  - Gaps in i_valid are permitted with no timeout.
  - i_start is ignored.
- DONE:
  - o_valid=1, o_ready=0; o_sum and o_ovf held stable while i_ready=0.
  - o_valid && i_ready: go to IDLE and drop o_valid.
  - o_sum and o_ovf keep their last values in IDLE until the next start.
  - i_start in the same cycle as the DONE->IDLE handshake is ignored; a new start is accepted from IDLE only.
- Arithmetic:
  - i_p is sign-extended to ACC_W.
  - Signed overflow on any add: operands of equal sign and result sign differing.
  - On overflow, o_ovf is set and stays set until the next accepted start or reset.
  - Default result wraps modulo 2^ACC_W.
- Input range: the pair (-2^(N-1))*(-2^(N-1)) is not representable in 2N-1 bits upstream and is out of scope for this block.

Optional Feature:
- Macro PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on overflow the accumulator clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Subsequent adds proceed from the clamped value and saturate again if needed. o_ovf is set as usual.
- Not defined: two's-complement wrap; no saturation logic is instantiated.

Test Plan:
- Basic run: i_len=3; i_p=100, -50, 7 back-to-back -> one cycle after the 3rd transfer, o_valid=1, o_sum=57, o_ovf=0; with i_ready=1 the block returns to IDLE and o_busy=0.
- Zero length: i_start with i_len=0 -> next cycle DONE with o_valid=1, o_sum=0; o_ready stays 0 throughout.
- Backpressure and gaps:
  - i_len=4, i_p=-1 four times with i_valid toggling on alternate cycles -> o_sum=0xFFFFFC.
  - Hold i_ready=0 for 5 cycles -> o_sum stays stable, o_valid stays 1, and i_start pulses are ignored.
- Overflow (ACC_W=16): i_len=3, i_p=16383 x3.
  - Without macro -> o_sum=-16387 (0xBFFD), o_ovf=1.
  - With PRODUCT_ACCUMULATOR_SATURATE_EN -> o_sum=32767, o_ovf=1.
  - Next run with small values -> o_ovf=0.
- Reset mid-run: i_len=5; assert reset after 2 transfers -> next cycle all outputs 0 and state IDLE. A new run (i_len=2; i_p=3, 4) gives o_sum=7.
- Sign-extension corner: i_len=2; i_p=0x4000 (-16384), i_p=0x3FFF (16383) -> o_sum=-1, o_ovf=0.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the Booth multiplier, the product accumulator and its consumer.
// Latency: none, wires only.
// Backpressure: carries o_ready (product side) and i_ready (result side).
//
// Signals (directions seen from the accumulator / slave modport):
//   i_start, i_len          run control: start pulse and term count
//   i_p, i_valid, o_ready   product stream from the multiplier
//   o_sum, o_valid, i_ready result stream to the consumer
//   o_busy, o_ovf           status: not idle, sticky overflow for current run
interface product_accumulator_if #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic               i_start;
  logic [CNT_W-1:0]   i_len;
  logic [2*N-2:0]     i_p;
  logic               i_valid;
  logic               o_ready;
  logic [ACC_W-1:0]   o_sum;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_ovf;

  // Master drives the run, the products and the result-side ready.
  modport master (
    output i_start, i_len, i_p, i_valid, i_ready,
    input  o_ready, o_sum, o_valid, o_busy, o_ovf
  );

  // Slave is the accumulator itself.
  modport slave (
    input  i_start, i_len, i_p, i_valid, i_ready,
    output o_ready, o_sum, o_valid, o_busy, o_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed (2N-1)-bit products into an ACC_W-bit accumulator.
// Latency: result valid 1 cycle after the last product transfer (1 cycle after start for i_len==0).
// Backpressure: o_ready high only while accumulating; result held in DONE until i_ready.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  synchronous active-high reset, discards any partial run
//   bus    product_accumulator_if.slave (run control, product stream, result stream, status)
//
// Build option: define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the accumulator on
// signed overflow instead of wrapping modulo 2^ACC_W. o_ovf is sticky in both builds.
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  product_accumulator_if.slave   bus
);

  localparam int P_W = 2*N - 1;

  // The accumulator must be able to hold at least one full product.
  if (ACC_W < P_W) begin : g_width_check
    $error("product_accumulator: ACC_W (%0d) must be >= 2N-1 (%0d)", ACC_W, P_W);
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]         remaining;
  logic [CNT_W-1:0]         remaining_nxt;
  logic                     ovf;
  logic                     ovf_nxt;

  // Datapath: one adder, overflow detect, optional clamp.
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  add_res;
  logic                     add_ovf;
  logic                     xfer;

  // Size cast of a signed operand sign-extends the product to the accumulator width.
  assign p_ext = ACC_W'($signed(bus.i_p));
  assign sum   = acc + p_ext;

  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Overflow can only occur with equal-sign operands, so the accumulator sign
  // tells the direction: non-negative operands overflow upward.
  assign add_res = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign add_res = sum;
`endif

  // In ACCUM o_ready is constantly high, so a valid product is a transfer.
  assign xfer = (state == ACCUM) && bus.i_valid;

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;

    unique case (state)
      IDLE: begin
        if (bus.i_start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.i_len != '0) begin
            remaining_nxt = bus.i_len;
            state_nxt     = ACCUM;
          end else begin
            // Empty run: report a zero sum straight away.
            state_nxt = DONE;
          end
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_nxt       = add_res;
          ovf_nxt       = ovf | add_ovf;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        // A start arriving together with this handshake is not seen: the
        // block only samples i_start in IDLE.
        if (bus.i_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

  // Outputs are registers or pure state decodes; nothing from i_* reaches o_*
  // without passing a flop.
  assign bus.o_ready = (state == ACCUM);
  assign bus.o_valid = (state == DONE);
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_sum   = acc;
  assign bus.o_ovf   = ovf;

  // A stalled result must not move.
  a_result_stable : assert property (
    @(posedge clk) disable iff (reset)
      (bus.o_valid && !bus.i_ready) |=> (bus.o_valid && $stable(bus.o_sum) && $stable(bus.o_ovf))
  );

  // Product and result sides are never open at the same time.
  a_ready_valid_excl : assert property (
    @(posedge clk) disable iff (reset)
      !(bus.o_ready && bus.o_valid)
  );

  // While accumulating there is always at least one term left.
  a_remaining_nonzero : assert property (
    @(posedge clk) disable iff (reset)
      (state == ACCUM) |-> (remaining != '0)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (ACC_W=16 so the overflow cases are reachable).
// Latency: checks result one cycle after the last product transfer.
// Backpressure: exercises i_valid gaps and i_ready stalls with ignored start pulses.
module tb_product_accumulator;

  localparam int N     = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int P_W   = 2*N - 1;

  localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W-1));
  localparam longint MODV = longint'(1) << ACC_W;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  product_accumulator_if #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  product_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact sum in a wide integer, then range-checked against the
  // accumulator's signed range.
  function automatic exp_t model(input int ps[$]);
    exp_t   e;
    longint a;
    longint s;
    a     = 0;
    e.ovf = 1'b0;
    foreach (ps[i]) begin
      s = a + longint'(ps[i]);
      if (s > MAXV || s < MINV) begin
        e.ovf = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        a = (s > MAXV) ? MAXV : MINV;
`else
        a = (s > MAXV) ? (s - MODV) : (s + MODV);
`endif
      end else begin
        a = s;
      end
    end
    e.sum = a[ACC_W-1:0];
    return e;
  endfunction

  // One complete run: start, products, result check, optional stall, handshake.
  task automatic run(input string name, input int ps[$], input bit gaps, input int hold);
    exp_t             e;
    logic [ACC_W-1:0] held;
    int               len;
    len = ps.size();

    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(bus.o_busy), 0);
    bus.i_start = 1'b1;
    bus.i_len   = CNT_W'(len);
    sb_q.push_back(model(ps));
    @(negedge clk);
    bus.i_start = 1'b0;

    foreach (ps[i]) begin
      if (gaps && i > 0) begin
        // Idle product slot; a start here must be ignored.
        bus.i_valid = 1'b0;
        bus.i_start = 1'b1;
        bus.i_len   = CNT_W'(9);
        @(negedge clk);
        bus.i_start = 1'b0;
      end
      for (int t = 0; t < 50 && !bus.o_ready; t++) @(negedge clk);
      if (!bus.o_ready) chk({name, "_ready_timeout"}, 0, 1);
      bus.i_p     = P_W'(ps[i]);
      bus.i_valid = 1'b1;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_p     = P_W'($urandom);

    chk({name, "_latency_vld"}, 32'(bus.o_valid), 1);
    if (len == 0) chk({name, "_zero_rdy"}, 32'(bus.o_ready), 0);
    for (int t = 0; t < 50 && !bus.o_valid; t++) @(negedge clk);
    if (!bus.o_valid) chk({name, "_valid_timeout"}, 0, 1);

    e = sb_q.pop_front();
    chk({name, "_sum"}, 32'(bus.o_sum), 32'(e.sum));
    chk({name, "_ovf"}, 32'(bus.o_ovf), 32'(e.ovf));
    held = bus.o_sum;

    repeat (hold) begin
      bus.i_start = 1'b1;
      bus.i_len   = CNT_W'(3);
      @(negedge clk);
      chk({name, "_hold_vld"}, 32'(bus.o_valid), 1);
      chk({name, "_hold_sum"}, 32'(bus.o_sum), 32'(held));
    end

    // Handshake; any start still asserted alongside it must be ignored.
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
    chk({name, "_post_vld"},  32'(bus.o_valid), 0);
    chk({name, "_post_busy"}, 32'(bus.o_busy), 0);
    chk({name, "_post_sum"},  32'(bus.o_sum), 32'(e.sum));
    chk({name, "_post_ovf"},  32'(bus.o_ovf), 32'(e.ovf));
  endtask

  initial begin
    int q[$];

    bus.i_start = 1'b0;
    bus.i_len   = '0;
    bus.i_p     = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sum",   32'(bus.o_sum),   0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_busy",  32'(bus.o_busy),  0);
    chk("rst_ovf",   32'(bus.o_ovf),   0);
    reset = 1'b0;

    // Products offered while idle are not taken.
    bus.i_p     = P_W'(500);
    bus.i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.o_ready), 0);
      chk("idle_sum",   32'(bus.o_sum),   0);
    end
    bus.i_valid = 1'b0;

    q = {100, -50, 7};
    run("basic", q, 1'b0, 0);

    q = {};
    run("zero_len", q, 1'b0, 0);

    q = {-1, -1, -1, -1};
    run("gaps_stall", q, 1'b1, 5);

    q = {16383, 16383, 16383};
    run("overflow", q, 1'b0, 0);

    q = {5, -2};
    run("ovf_clear", q, 1'b0, 0);

    q = {-16384, 16383};
    run("sext", q, 1'b0, 0);

    q = {-16384, -16384, -16384};
    run("neg_ovf", q, 1'b0, 2);

    // Reset in the middle of a run discards the partial sum.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = CNT_W'(5);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (2) begin
      bus.i_p     = P_W'(1000);
      bus.i_valid = 1'b1;
      @(negedge clk);
    end
    chk("mid_busy", 32'(bus.o_busy), 1);
    chk("mid_sum",  32'(bus.o_sum),  2000);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    chk("mrst_sum",   32'(bus.o_sum),   0);
    chk("mrst_valid", 32'(bus.o_valid), 0);
    chk("mrst_ready", 32'(bus.o_ready), 0);
    chk("mrst_busy",  32'(bus.o_busy),  0);
    chk("mrst_ovf",   32'(bus.o_ovf),   0);

    q = {3, 4};
    run("after_rst", q, 1'b0, 0);

    // A longer random run through the same model.
    q = {};
    for (int i = 0; i < 20; i++) q.push_back($urandom_range(0, 2000) - 1000);
    run("random", q, 1'b0, 0);

    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

endmodule
